// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared Johnson-code types and decode helpers
package johnson_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  // Helpers take a zero-extended code plus the real width n, so one
  // package serves every counter width up to JP_MAX_N.
  localparam int JP_MAX_N = 64;

  function automatic logic johnson_legal(input logic [JP_MAX_N-1:0] code, input int n);
    int trans;
    trans = 0;
    for (int i = 0; i < JP_MAX_N - 1; i++) begin
      if (i < n - 1 && code[i] != code[i+1]) trans++;
    end
    return (trans <= 1);
  endfunction

  function automatic int johnson_idx(input logic [JP_MAX_N-1:0] code, input int n);
    int pop;
    pop = 0;
    for (int i = 0; i < JP_MAX_N; i++) begin
      if (i < n && code[i]) pop++;
    end
    return code[0] ? (2 * n - pop) : pop;
  endfunction

endpackage

// File: rtl/johnson_code_check.sv
// rtl/johnson_code_check.sv - combinational Johnson legality check and phase decode
module johnson_code_check #(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(2 * N)
) (
  input  logic [N-1:0]     code,
  output logic             legal,
  output logic [IDX_W-1:0] idx
);
  import johnson_pkg::*;

  logic [JP_MAX_N-1:0] w_code_ext;

  assign w_code_ext = JP_MAX_N'(code);
  assign legal      = johnson_legal(w_code_ext, N);
  assign idx        = IDX_W'(johnson_idx(w_code_ext, N));

endmodule

// File: rtl/johnson_phase_decoder.sv
// rtl/johnson_phase_decoder.sv - Johnson phase decode, lock FSM and error counting
module johnson_phase_decoder #(
  parameter  int N          = 8,
  parameter  int LOCK_COUNT = 3,
  parameter  int ERR_W      = 8,
  localparam int IDX_W      = $clog2(2 * N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N-1:0]     johnson_in,
  output logic             out_valid,
  output logic [IDX_W-1:0] phase_idx,
  output logic [2*N-1:0]   phase_onehot,
  output logic             locked,
  output logic             wrap,
  output logic             illegal,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count
);
  import johnson_pkg::*;

  localparam int               MC_W     = $clog2(LOCK_COUNT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * N - 1);

  state_t           r_state, w_state_nxt;
  logic [MC_W-1:0]  r_match_cnt, w_match_nxt;
  logic [IDX_W-1:0] r_expect, w_expect_nxt;
  logic [IDX_W-1:0] r_phase_idx, w_idx_nxt;
  logic [2*N-1:0]   r_phase_onehot, w_onehot_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_wrap, w_wrap_nxt;
  logic             r_illegal, w_illegal_nxt;
  logic             r_seq_err, w_seq_err_nxt;
  logic [ERR_W-1:0] r_err_count, w_err_nxt;
  logic             w_err_event;
  logic             w_legal;
  logic [IDX_W-1:0] w_idx;

  johnson_code_check #(.N(N)) u_check (
    .code  (johnson_in),
    .legal (w_legal),
    .idx   (w_idx)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_match_nxt     = r_match_cnt;
    w_expect_nxt    = r_expect;
    w_idx_nxt       = r_phase_idx;
    w_onehot_nxt    = r_phase_onehot;
    w_out_valid_nxt = 1'b0;
    w_wrap_nxt      = 1'b0;
    w_illegal_nxt   = 1'b0;
    w_seq_err_nxt   = 1'b0;
    w_err_event     = 1'b0;

    if (in_valid) begin
      if (!w_legal) begin
        w_illegal_nxt = 1'b1;
        w_state_nxt   = UNLOCKED;
        w_match_nxt   = '0;
        w_err_event   = 1'b1;
      end else begin
        w_out_valid_nxt = 1'b1;
        w_idx_nxt       = w_idx;
        w_onehot_nxt    = {{(2*N-1){1'b0}}, 1'b1} << w_idx;
        w_expect_nxt    = (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;

        unique case (r_state)
          UNLOCKED: begin
            w_match_nxt = MC_W'(1);
            w_state_nxt = (LOCK_COUNT == 1) ? LOCKED : ACQUIRE;
          end
          ACQUIRE: begin
            if (w_idx == r_expect) begin
              if (int'(r_match_cnt) + 1 >= LOCK_COUNT) begin
                w_match_nxt = MC_W'(LOCK_COUNT);
                w_state_nxt = LOCKED;
              end else begin
                w_match_nxt = r_match_cnt + 1'b1;
              end
            end else begin
              // Restart acquisition anchored on the new phase; not an error.
              w_match_nxt = MC_W'(1);
            end
          end
          LOCKED: begin
            if (w_idx == r_expect) begin
              w_wrap_nxt = (w_idx == '0);
            end else begin
              w_seq_err_nxt = 1'b1;
              w_err_event   = 1'b1;
              w_state_nxt   = ACQUIRE;
              w_match_nxt   = MC_W'(1);
            end
          end
          default: begin
            w_state_nxt = UNLOCKED;
            w_match_nxt = '0;
          end
        endcase
      end
    end

    w_err_nxt = (w_err_event && (r_err_count != {ERR_W{1'b1}})) ? r_err_count + 1'b1 : r_err_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= UNLOCKED;
      r_match_cnt    <= '0;
      r_expect       <= '0;
      r_phase_idx    <= '0;
      r_phase_onehot <= '0;
      r_out_valid    <= 1'b0;
      r_wrap         <= 1'b0;
      r_illegal      <= 1'b0;
      r_seq_err      <= 1'b0;
      r_err_count    <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_match_cnt    <= w_match_nxt;
      r_expect       <= w_expect_nxt;
      r_phase_idx    <= w_idx_nxt;
      r_phase_onehot <= w_onehot_nxt;
      r_out_valid    <= w_out_valid_nxt;
      r_wrap         <= w_wrap_nxt;
      r_illegal      <= w_illegal_nxt;
      r_seq_err      <= w_seq_err_nxt;
      r_err_count    <= w_err_nxt;
    end
  end

  assign out_valid    = r_out_valid;
  assign phase_idx    = r_phase_idx;
  assign phase_onehot = r_phase_onehot;
  assign locked       = (r_state == LOCKED);
  assign wrap         = r_wrap;
  assign illegal      = r_illegal;
  assign seq_err      = r_seq_err;
  assign err_count    = r_err_count;

endmodule
